// File: rtl/pdm_pcm_multi_decimator_if.sv
// Stream bundle for the decimator: PDM bit input side and PCM frame output side.
// The master modport is the decimator's view; the slave modport is the surrounding logic.
interface pdm_pcm_multi_decimator_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 16
);
    logic [NUM_CHANNELS-1:0]            pdm_data_i;
    logic                               pdm_valid_i;
    logic                               pdm_ready_o;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] pcm_data_o;
    logic                               pcm_valid_o;
    logic                               pcm_ready_i;

    modport master (
        input  pdm_data_i, pdm_valid_i, pcm_ready_i,
        output pdm_ready_o, pcm_data_o, pcm_valid_o
    );

    modport slave (
        output pdm_data_i, pdm_valid_i, pcm_ready_i,
        input  pdm_ready_o, pcm_data_o, pcm_valid_o
    );
endinterface

// File: rtl/pdm_pcm_multi_decimator.sv
// Boxcar PDM->PCM decimator for NUM_CHANNELS lock-step streams with a show-ahead frame FIFO.
// Frame pushed at the edge ending EMIT; PDM input never stalls, full FIFO drops frames (counted).
module pdm_pcm_multi_decimator #(
    parameter int NUM_CHANNELS   = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_RATIO_LOG2 = 7,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                              clock_i,
    input  logic                              reset_n_i,
    input  logic                              enable_i,
    input  logic [$clog2(MAX_RATIO_LOG2+1)-1:0] ratio_log2_i,
    input  logic                              clear_flags_i,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o,
    output logic                              busy_o,
    output logic                              overflow_o,
    output logic [15:0]                       drop_count_o,
    pdm_pcm_multi_decimator_if.master         bus
);
    localparam int RLW = $clog2(MAX_RATIO_LOG2 + 1);
    localparam int CW  = MAX_RATIO_LOG2 + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = NUM_CHANNELS * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] PCM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] PCM_MAX = ~PCM_MIN;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT} state_e;

    state_e                       state_q, state_d;
    logic [RLW-1:0]               l_q, l_d;
    logic [CW-1:0]                bit_cnt_q, bit_cnt_d;
    logic [NUM_CHANNELS-1:0][CW-1:0] ones_q, ones_d;
    logic [AW:0]                  wptr_q, wptr_d, rptr_q, rptr_d;
    logic                         overflow_q, overflow_d;
    logic [15:0]                  drop_cnt_q, drop_cnt_d;
    logic [FW-1:0]                mem_q [FIFO_DEPTH];

    logic          accept, last_bit, emit, full, empty, pop, push, drop;
    logic [CW-1:0] r_val;
    logic [AW:0]   level;
    logic [FW-1:0] frame;

    function automatic logic [RLW-1:0] clamp_l(input logic [RLW-1:0] r);
        if ({1'b0, r} < (RLW+1)'(2))
            return RLW'(2);
        else if ({1'b0, r} > (RLW+1)'(MAX_RATIO_LOG2))
            return RLW'(MAX_RATIO_LOG2);
        else
            return r;
    endfunction

    assign accept   = bus.pdm_valid_i && bus.pdm_ready_o;
    assign r_val    = CW'(1) << l_q;
    assign last_bit = (state_q == S_ACCUM) && accept && (CW'(bit_cnt_q + CW'(1)) == r_val);
    assign emit     = (state_q == S_EMIT);
    assign level    = wptr_q - rptr_q;
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign pop      = !empty && bus.pcm_ready_i;
    assign push     = emit && (!full || pop);
    assign drop     = emit && full && !pop;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable_i) state_d = S_ACCUM;
            S_ACCUM: if (!enable_i) state_d = S_IDLE;
                     else if (last_bit) state_d = S_EMIT;
            S_EMIT:  state_d = enable_i ? S_ACCUM : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        bus.pdm_ready_o = enable_i && reset_n_i;
        busy_o          = (state_q != S_IDLE) || !empty;
    end

    // Bits accepted during EMIT seed the next frame's counters.
    always_comb begin
        l_d       = l_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                ones_d    = '0;
                if (enable_i) l_d = clamp_l(ratio_log2_i);
            end
            S_ACCUM: begin
                if (!enable_i) begin
                    bit_cnt_d = '0;
                    ones_d    = '0;
                end else if (accept) begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    for (int n = 0; n < NUM_CHANNELS; n++)
                        ones_d[n] = ones_q[n] + CW'(bus.pdm_data_i[n]);
                end
            end
            S_EMIT: begin
                l_d       = clamp_l(ratio_log2_i);
                bit_cnt_d = accept ? CW'(1) : '0;
                for (int n = 0; n < NUM_CHANNELS; n++)
                    ones_d[n] = accept ? CW'(bus.pdm_data_i[n]) : '0;
            end
            default: begin
                bit_cnt_d = '0;
                ones_d    = '0;
            end
        endcase
    end

    // Full-scale count would land exactly on +2^(DW-1), so it saturates instead of wrapping.
    always_comb begin
        frame = '0;
        for (int n = 0; n < NUM_CHANNELS; n++) begin
            if (ones_q[n] == r_val)
                frame[n*DATA_WIDTH +: DATA_WIDTH] = PCM_MAX;
            else
                frame[n*DATA_WIDTH +: DATA_WIDTH] =
                    (DATA_WIDTH'(ones_q[n]) << (DATA_WIDTH - int'(l_q))) - PCM_MIN;
        end
    end

    always_comb begin
        wptr_d     = wptr_q + (AW+1)'(push);
        rptr_d     = rptr_q + (AW+1)'(pop);
        overflow_d = clear_flags_i ? 1'b0 : overflow_q;
        drop_cnt_d = clear_flags_i ? 16'd0 : drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_d != 16'hFFFF) drop_cnt_d = drop_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            l_q        <= RLW'(2);
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            l_q        <= l_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= frame;
    end

    assign bus.pcm_valid_o = !empty;
    assign bus.pcm_data_o  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign fifo_level_o    = level;
    assign overflow_o      = overflow_q;
    assign drop_count_o    = drop_cnt_q;
endmodule

// File: tb/tb_pdm_pcm_multi_decimator.sv
// Directed bench for pdm_pcm_multi_decimator (2 channels, 16-bit, depth 16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pdm_pcm_multi_decimator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  ratio;
    logic        clear;
    logic [4:0]  level;
    logic        busy, ovf;
    logic [15:0] drops;
    int          errors = 0;
    int          checks = 0;

    pdm_pcm_multi_decimator_if #(.NUM_CHANNELS(2), .DATA_WIDTH(16)) bus ();

    pdm_pcm_multi_decimator #(
        .NUM_CHANNELS(2), .DATA_WIDTH(16), .MAX_RATIO_LOG2(7), .FIFO_DEPTH(16)
    ) dut (
        .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable), .ratio_log2_i(ratio),
        .clear_flags_i(clear), .fifo_level_o(level), .busy_o(busy), .overflow_o(ovf),
        .drop_count_o(drops), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ratio;
        logic [31:0] p0, p1;
        int          nbeats;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic beat(input logic [1:0] bits);
        @(negedge clk);
        bus.pdm_data_i  = bits;
        bus.pdm_valid_i = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.pdm_valid_i = 1'b0;
        bus.pdm_data_i  = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; ratio = 3'd4; clear = 1'b0;
        bus.pdm_data_i = 2'b00; bus.pdm_valid_i = 1'b0; bus.pcm_ready_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [15:0] exp_pcm16(input int ones);
        int v;
        v = (ones << 12) - 32'h8000;
        return (ones == 16) ? 16'h7FFF : v[15:0];
    endfunction

    // Frame k of the streaming tests: ch0 carries k ones, ch1 carries 16-k ones.
    function automatic logic [1:0] kbits(input int k, input int b);
        return {(b >= k) ? 1'b1 : 1'b0, (b < k) ? 1'b1 : 1'b0};
    endfunction

    function automatic logic [31:0] kframe(input int k);
        return {exp_pcm16(16 - k), exp_pcm16(k)};
    endfunction

    int qk[$];

    initial begin
        vecs[0] = '{3'd4, 32'h0000_0000, 32'hFFFF_FFFF, 16,  16'h8000, 16'h7FFF};
        vecs[1] = '{3'd4, 32'hAAAA_AAAA, 32'h5555_5555, 16,  16'h0000, 16'h0000};
        vecs[2] = '{3'd2, 32'h0000_0001, 32'h0000_0007, 4,   16'hC000, 16'h4000};
        vecs[3] = '{3'd0, 32'h0000_000F, 32'h0000_0003, 4,   16'h7FFF, 16'h0000};
        vecs[4] = '{3'd7, 32'h0000_FFFF, 32'h0000_0001, 128, 16'h0000, 16'h8800};
        vecs[5] = '{3'd3, 32'h0000_000F, 32'h0000_0001, 8,   16'h0000, 16'hA000};
        vecs[6] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFE, 32,  16'h8800, 16'h7800};

        // Reset held while inputs toggle: all outputs stay 0.
        rst_n = 1'b0; enable = 1'b0; ratio = 3'd4; clear = 1'b0;
        bus.pdm_data_i = 2'b00; bus.pdm_valid_i = 1'b0; bus.pcm_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            enable = i[0]; clear = ~i[0]; bus.pdm_valid_i = 1'b1;
            bus.pdm_data_i = i[1:0]; bus.pcm_ready_i = i[1];
            #1;
            check("reset_outputs", {bus.pdm_ready_o, bus.pcm_valid_o, bus.pcm_data_o,
                                    level, busy, ovf, drops}, 64'd0);
        end
        do_reset();

        // Single-frame vectors.
        for (int v = 0; v < 7; v++) begin
            ratio = vecs[v].ratio; enable = 1'b1;
            step();
            for (int b = 0; b < vecs[v].nbeats; b++)
                beat({vecs[v].p1[b % 32], vecs[v].p0[b % 32]});
            idle();
            idle();
            check($sformatf("vec%0d_valid", v), bus.pcm_valid_o, 1'b1);
            check($sformatf("vec%0d_ch0", v), bus.pcm_data_o[15:0], vecs[v].e0);
            check($sformatf("vec%0d_ch1", v), bus.pcm_data_o[31:16], vecs[v].e1);
            bus.pcm_ready_i = 1'b1;
            step();
            bus.pcm_ready_i = 1'b0;
            check($sformatf("vec%0d_level_after_pop", v), level, 5'd0);
            enable = 1'b0;
            step();
        end

        // Ratio change mid-frame only takes effect on the next frame.
        do_reset();
        ratio = 3'd4; enable = 1'b1;
        step();
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            if (j == 16) check("ratio_chg_level_before_push", level, 5'd0);
            if (j == 17) check("ratio_chg_level_after_16", level, 5'd1);
            if (j == 8) ratio = 3'd5;
            bus.pdm_data_i = 2'b01; bus.pdm_valid_i = 1'b1;
        end
        idle();
        check("ratio_chg_frame2_not_early", level, 5'd1);
        idle();
        check("ratio_chg_frame2_at_32", level, 5'd2);
        check("ratio_chg_f1", bus.pcm_data_o, 32'h8000_7FFF);
        bus.pcm_ready_i = 1'b1;
        step();
        check("ratio_chg_f2", bus.pcm_data_o, 32'h8000_7FFF);
        step();
        bus.pcm_ready_i = 1'b0;
        check("ratio_chg_empty", bus.pcm_valid_o, 1'b0);
        enable = 1'b0;

        // Overflow: 18 frames into a 16-deep FIFO with the sink stalled.
        do_reset();
        ratio = 3'd4; enable = 1'b1;
        step();
        for (int k = 0; k < 18; k++)
            for (int b = 0; b < 16; b++) beat(kbits(k, b));
        idle();
        idle();
        check("ovf_level", level, 5'd16);
        check("ovf_flag", ovf, 1'b1);
        check("ovf_drop_count", drops, 16'd2);
        check("ovf_head", bus.pcm_data_o, kframe(0));
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_flag", ovf, 1'b0);
        check("clear_count", drops, 16'd0);

        // Clear held through a drop: the drop wins.
        clear = 1'b1;
        for (int b = 0; b < 16; b++) beat(kbits(5, b));
        idle();
        step();
        clear = 1'b0;
        check("clear_drop_flag", ovf, 1'b1);
        check("clear_drop_count", drops, 16'd1);
        check("clear_drop_level", level, 5'd16);

        // Full FIFO with pop and push in the EMIT cycle: both succeed.
        for (int b = 0; b < 16; b++) beat(kbits(16, b));
        idle();
        bus.pcm_ready_i = 1'b1;
        step();
        bus.pcm_ready_i = 1'b0;
        check("popush_level", level, 5'd16);
        check("popush_count", drops, 16'd1);
        for (int k = 1; k < 16; k++) qk.push_back(k);
        qk.push_back(16);

        // Drain: one frame per cycle, in order, no gaps.
        bus.pcm_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            check($sformatf("drain%0d_valid", i), bus.pcm_valid_o, 1'b1);
            check($sformatf("drain%0d_data", i), bus.pcm_data_o, kframe(qk[i]));
        end
        step();
        bus.pcm_ready_i = 1'b0;
        check("drain_empty_valid", bus.pcm_valid_o, 1'b0);
        check("drain_empty_level", level, 5'd0);
        enable = 1'b0;

        // Enable dropped mid-frame discards the partial frame.
        do_reset();
        ratio = 3'd4; enable = 1'b1;
        step();
        for (int b = 0; b < 10; b++) beat(2'b11);
        idle();
        enable = 1'b0;
        check("abort_busy_partial", busy, 1'b1);
        step();
        check("abort_busy_idle", busy, 1'b0);
        check("abort_level", level, 5'd0);
        enable = 1'b1;
        step();
        for (int b = 0; b < 16; b++) beat(2'b00);
        idle();
        idle();
        check("abort_level_one", level, 5'd1);
        check("abort_frame", bus.pcm_data_o, 32'h8000_8000);
        bus.pcm_ready_i = 1'b1;
        step();
        bus.pcm_ready_i = 1'b0;
        step();
        check("abort_single_frame", level, 5'd0);

        // Reset mid-transfer with a stored frame and a partial frame.
        for (int b = 0; b < 16; b++) beat(2'b11);
        idle();
        idle();
        check("midrst_stored", level, 5'd1);
        for (int b = 0; b < 5; b++) beat(2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {bus.pdm_ready_o, bus.pcm_valid_o, bus.pcm_data_o,
                                 level, busy, ovf, drops}, 64'd0);
        enable = 1'b0; bus.pdm_valid_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("midrst_after_release", {bus.pcm_valid_o, level, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
